// File: rtl/uart_rx.sv
// 8-bit LSB-first UART receiver. It oversamples the line, takes a 3-sample majority vote per bit, and emits valid/error strobes.
// Define UART_RX_PARITY_EN to add one even-parity bit after data bit 7 (11-bit frame).
module uart_rx #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int OVERSAMPLE  = 16
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       parity_err_o,
    output logic       busy_o
);

    localparam int DIV = CLK_FREQ_HZ / (BAUD * OVERSAMPLE);
    localparam int TW  = $clog2(DIV + 1);
    localparam int SW  = $clog2(OVERSAMPLE);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
    localparam logic [SW-1:0] SAMP_A    = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] SAMP_B    = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] SAMP_VOTE = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] SAMP_LAST = SW'(OVERSAMPLE - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    logic          r_sync_meta;
    logic          r_rx_s;
    logic [2:0]    r_state;
    logic [TW-1:0] r_tick_cnt;
    logic [SW-1:0] r_samp_cnt;
    logic [2:0]    r_bit_cnt;
    logic          r_samp_a;
    logic          r_samp_b;
    logic [7:0]    r_shift;
    logic [7:0]    r_byte;
    logic          r_valid;
    logic          r_ferr;
    logic          r_perr;
    logic          r_busy;

    logic w_tick;
    logic w_vote_tick;
    logic w_bit_end;
    logic w_vote;
    logic w_par_bad;
    logic w_counting;

    assign w_tick      = (r_tick_cnt == TICK_LAST);
    assign w_vote_tick = w_tick && (r_samp_cnt == SAMP_VOTE);
    assign w_bit_end   = w_tick && (r_samp_cnt == SAMP_LAST);
    assign w_vote      = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);
    assign w_counting  = (r_state != S_IDLE) && (r_state != S_BREAK);

`ifdef UART_RX_PARITY_EN
    logic r_par_bit;
    // Even parity: data bits plus the parity bit must XOR to zero.
    assign w_par_bad = ^{r_shift, r_par_bit};

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_par_bit <= 1'b0;
        end else if (r_state == S_PARITY && w_vote_tick) begin
            r_par_bit <= w_vote;
        end
    end
`else
    assign w_par_bad = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_sync_meta <= 1'b1;
            r_rx_s      <= 1'b1;
            r_state     <= S_IDLE;
            r_tick_cnt  <= '0;
            r_samp_cnt  <= '0;
            r_bit_cnt   <= '0;
            r_samp_a    <= 1'b1;
            r_samp_b    <= 1'b1;
            r_shift     <= '0;
            r_byte      <= '0;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sync_meta <= rx_i;
            r_rx_s      <= r_sync_meta;
            r_valid     <= 1'b0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;

            // Counters sit at zero while idle, so the start edge always begins a fresh bit.
            if (!w_counting) begin
                r_tick_cnt <= '0;
                r_samp_cnt <= '0;
            end else if (w_tick) begin
                r_tick_cnt <= '0;
                r_samp_cnt <= (r_samp_cnt == SAMP_LAST) ? '0 : r_samp_cnt + 1'b1;
            end else begin
                r_tick_cnt <= r_tick_cnt + 1'b1;
            end

            if (w_tick && r_samp_cnt == SAMP_A) r_samp_a <= r_rx_s;
            if (w_tick && r_samp_cnt == SAMP_B) r_samp_b <= r_rx_s;

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_vote_tick && w_vote) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_bit_end) begin
                        r_state   <= S_DATA;
                        r_bit_cnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_vote_tick) r_shift <= {w_vote, r_shift[7:1]};
                    if (w_bit_end) begin
                        if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) r_state <= S_STOP;
                end
`endif
                S_STOP: begin
                    // Finish on the vote rather than at the end of the bit, so back-to-back frames are not missed.
                    if (w_vote_tick) begin
                        if (!w_vote) begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end else if (w_par_bad) begin
                            r_perr  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_byte  <= r_shift;
                            r_valid <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign byte_o       = r_byte;
    assign valid_o      = r_valid;
    assign frame_err_o  = r_ferr;
    assign parity_err_o = r_perr;
    assign busy_o       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: serial frames are generated from byte values, and the expected strobes are queued and checked by a monitor.
module tb_uart_rx;
    localparam int CLK_HZ = 800_000;
    localparam int BAUD_R = 10_000;
    localparam int OS     = 16;
    localparam int DIV    = CLK_HZ / (BAUD_R * OS);
    localparam int BIT    = DIV * OS;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       rx_i = 1'b1;
    logic [7:0] byte_o;
    logic       valid_o, frame_err_o, parity_err_o, busy_o;

    uart_rx #(.CLK_FREQ_HZ(CLK_HZ), .BAUD(BAUD_R), .OVERSAMPLE(OS)) dut (
        .clk_i(clk), .reset_i(reset_i), .rx_i(rx_i), .byte_o(byte_o),
        .valid_o(valid_o), .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    // kind: 0 = valid byte, 1 = frame error, 2 = parity error
    typedef struct {
        int         kind;
        logic [7:0] data;
    } exp_t;

    exp_t       sb_q[$];
    int         total = 0;
    int         bad = 0;
    logic [7:0] last_good = 8'h00;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid_o || frame_err_o || parity_err_o) begin
            exp_t e;
            int   k;
            k = valid_o ? 0 : (frame_err_o ? 1 : 2);
            chk("one_strobe", int'(valid_o) + int'(frame_err_o) + int'(parity_err_o), 1);
            if (sb_q.size() == 0) begin
                chk("unexpected_strobe_kind", k, 99);
            end else begin
                e = sb_q.pop_front();
                chk("strobe_kind", k, e.kind);
                if (e.kind == 0) last_good = e.data;
                chk("byte_o", int'(byte_o), int'(last_good));
                $display("rx event kind=%0d byte_o=0x%02h expected_kind=%0d", k, byte_o, e.kind);
            end
        end
    end

    task automatic drive_bit(input logic b);
        rx_i = b;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
        exp_t e;
        e.data = d;
`ifdef UART_RX_PARITY_EN
        e.kind = !stop ? 1 : (par_flip ? 2 : 0);
`else
        e.kind = !stop ? 1 : 0;
`endif
        sb_q.push_back(e);
        drive_bit(1'b0);
        chk("busy_in_frame", int'(busy_o), 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`else
        if (par_flip) rx_i = 1'b1;
`endif
        drive_bit(stop);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 2 * BIT) begin
            @(negedge clk);
            n++;
        end
        chk(name, sb_q.size(), 0);
        sb_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        reset_i = 1'b1;
        rx_i    = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_byte", int'(byte_o), 0);
        chk("reset_valid", int'(valid_o), 0);
        chk("reset_ferr", int'(frame_err_o), 0);
        chk("reset_perr", int'(parity_err_o), 0);
        chk("reset_busy", int'(busy_o), 0);
        reset_i = 1'b0;
        repeat (BIT) @(negedge clk);

        send_frame(8'h07, 1'b1, 1'b0);
        wait_drain("drain_07");
        send_frame(8'h99, 1'b1, 1'b0);
        send_frame(8'h69, 1'b1, 1'b0);
        wait_drain("drain_99_69");
        drive_bit(1'b1);

        // Short low pulse: start detected, then rejected at the start-bit vote.
        rx_i = 1'b0;
        repeat (3 * DIV) @(negedge clk);
        chk("glitch_busy_high", int'(busy_o), 1);
        rx_i = 1'b1;
        repeat (16 * DIV) @(negedge clk);
        chk("glitch_busy_low", int'(busy_o), 0);
        drive_bit(1'b1);

        send_frame(8'hA5, 1'b0, 1'b0);
        rx_i = 1'b0;
        repeat (5 * BIT) @(negedge clk);
        chk("break_busy_high", int'(busy_o), 1);
        chk("break_byte_kept", int'(byte_o), int'(last_good));
        rx_i = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_low", int'(busy_o), 0);
        wait_drain("drain_ferr");
        drive_bit(1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_drain("drain_3c");

        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            send_frame(d, 1'b1, 1'b0);
            rx_i = 1'b1;
            repeat ($urandom_range(0, BIT)) @(negedge clk);
        end
        wait_drain("drain_random");

        // Abandon a frame partway through data bit 4 using reset.
        d = 8'h81;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_i = d[4];
        repeat (BIT / 2) @(negedge clk);
        reset_i = 1'b1;
        rx_i    = 1'b1;
        @(posedge clk);
        #1;
        chk("midreset_byte", int'(byte_o), 0);
        chk("midreset_valid", int'(valid_o), 0);
        chk("midreset_ferr", int'(frame_err_o), 0);
        chk("midreset_perr", int'(parity_err_o), 0);
        chk("midreset_busy", int'(busy_o), 0);
        last_good = 8'h00;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0);
        wait_drain("drain_81");

`ifdef UART_RX_PARITY_EN
        drive_bit(1'b1);
        send_frame(8'h03, 1'b1, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1);
        wait_drain("drain_parity");
`endif

        repeat (BIT) @(negedge clk);
        chk("final_busy", int'(busy_o), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "watchdog expired");
    end

endmodule
